// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out for the HQ2x scaler: timing, scaler read/line/frame control, centred picture with border.
// Optional SCANLINES_EN: dims odd VGA lines in SHOW by halving each colour component before truncation.
module vga_scanout #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          PIC_X0     = 64,
    parameter logic [14:0] BORDER_RGB = 15'h0000,
    parameter int          RL_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] pixel,
    input  logic        frame_available,
    output logic [9:0]  read_x,
    output logic        reset_line,
    output logic        reset_frame,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic [1:0]  o_dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] PIC_BEG  = 10'(PIC_X0);
    localparam logic [9:0] PIC_END  = 10'(PIC_X0 + 512);
    localparam logic [9:0] RL_END   = 10'(H_ACTIVE + RL_CYCLES);
    localparam logic [9:0] RF_LINE  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] PRE_A    = 10'(V_TOTAL - 4);
    localparam logic [9:0] PRE_B    = 10'(V_TOTAL - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic pic;
        logic show;
    } stage_t;

    localparam stage_t STAGE_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0, pic: 1'b0, show: 1'b0};

    state_t      r_state;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic [9:0]  r_read_x;
    logic        r_reset_line;
    logic        r_reset_frame;
    stage_t      r_s1;
    stage_t      r_s2;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic [3:0]  r_r;
    logic [3:0]  r_g;
    logic [3:0]  r_b;

    logic [9:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic [9:0]  w_hx;
    stage_t      w_s0;
    logic        w_rl_line;
    logic        w_rl_next;
    logic        w_rf_next;
    logic [14:0] w_src;
    logic        w_unused;

    // Counter lookahead lets reset_line/reset_frame/state be registered yet line up with hc/vc exactly.
    always_comb begin
        w_hc_next = (r_hc == H_LAST) ? 10'd0 : r_hc + 10'd1;
        w_vc_next = r_vc;
        if (r_hc == H_LAST) begin
            w_vc_next = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end
    end

    always_comb begin
        w_hx       = r_hc - PIC_BEG;
        w_s0.hs    = !(r_hc >= HS_BEG && r_hc < HS_END);
        w_s0.vs    = !(r_vc >= VS_BEG && r_vc < VS_END);
        w_s0.act   = (r_hc < H_ACT) && (r_vc < V_ACT);
        w_s0.pic   = w_s0.act && (r_hc >= PIC_BEG) && (r_hc < PIC_END);
        w_s0.show  = (r_state == S_SHOW);
        w_rl_line  = ((w_vc_next < V_ACT) && w_vc_next[0]) || (w_vc_next == PRE_A) || (w_vc_next == PRE_B);
        w_rl_next  = w_rl_line && (w_hc_next >= H_ACT) && (w_hc_next < RL_END);
        w_rf_next  = (w_vc_next == RF_LINE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (frame_available) r_state <= S_ARMED;
                S_ARMED: if (w_hc_next == 10'd0 && w_vc_next == 10'd0) r_state <= S_SHOW;
                S_SHOW:  r_state <= S_SHOW;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_reset_line  <= 1'b0;
            r_reset_frame <= 1'b1;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_reset_line  <= w_rl_next;
            r_reset_frame <= w_rf_next;
        end
    end

`ifdef SCANLINES_EN
    logic r_odd1;
    logic r_odd2;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_odd1 <= 1'b0;
            r_odd2 <= 1'b0;
        end else begin
            r_odd1 <= r_vc[0];
            r_odd2 <= r_odd1;
        end
    end
`endif

    // Stage 1 issues the scaler read; stage 2 waits for its registered pixel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_read_x <= 10'd0;
            r_s1     <= STAGE_RST;
            r_s2     <= STAGE_RST;
        end else begin
            if (w_s0.pic) begin
                r_read_x <= {r_vc[0], w_hx[8:0]};
            end
            r_s1 <= w_s0;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_src = r_s2.pic ? pixel : BORDER_RGB;
`ifdef SCANLINES_EN
        if (r_odd2) begin
            w_src = {1'b0, w_src[14:11], 1'b0, w_src[9:6], 1'b0, w_src[4:1]};
        end
`endif
    end

    // Component LSBs are dropped by the 5->4 bit truncation.
    assign w_unused = &{1'b0, w_src[10], w_src[5], w_src[0], w_hx[9]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b1;
            r_r     <= 4'd0;
            r_g     <= 4'd0;
            r_b     <= 4'd0;
        end else begin
            r_hsync <= r_s2.hs;
            r_vsync <= r_s2.vs;
            r_blank <= !r_s2.act;
            if (r_s2.act && r_s2.show) begin
                r_r <= w_src[4:1];
                r_g <= w_src[9:6];
                r_b <= w_src[14:11];
            end else begin
                r_r <= 4'd0;
                r_g <= 4'd0;
                r_b <= 4'd0;
            end
        end
    end

    assign read_x      = r_read_x;
    assign reset_line  = r_reset_line;
    assign reset_frame = r_reset_frame;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-size instance for 640x480 line timing and a
// shrunken-timing instance (64x22 total) for frame-level behaviour within a short run.
module tb_vga_scanout;

    localparam int HT = 64;
    localparam int VT = 22;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] pixel;
    logic        frame_available;

    logic [9:0]  rx;
    logic        rl, rf, hs, vs, bl;
    logic [3:0]  vr, vg, vb;
    logic [1:0]  st;

    logic [14:0] f_pixel;
    logic        f_fa;
    logic [9:0]  f_rx;
    logic        f_rl, f_rf, f_hs, f_vs, f_bl;
    logic [3:0]  f_r, f_g, f_b;
    logic [1:0]  f_st;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [9:0] rx_q;

    vga_scanout #(
        .H_ACTIVE(48), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .PIC_X0(8), .BORDER_RGB(15'h5AB6), .RL_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel(pixel), .frame_available(frame_available),
        .read_x(rx), .reset_line(rl), .reset_frame(rf), .hsync(hs), .vsync(vs),
        .blank(bl), .vga_r(vr), .vga_g(vg), .vga_b(vb), .o_dbg_state(st)
    );

    vga_scanout dut_full (
        .clk(clk), .reset_n(reset_n), .pixel(f_pixel), .frame_available(f_fa),
        .read_x(f_rx), .reset_line(f_rl), .reset_frame(f_rf), .hsync(f_hs), .vsync(f_vs),
        .blank(f_bl), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .o_dbg_state(f_st)
    );

    always #20 clk = ~clk;

    // Registered scaler stand-in: pixel = {b=1F, g=00, r=read_x[4:0]}, one clock after read_x.
    always @(negedge clk) rx_q = rx;
    always @(posedge clk) begin
        #1;
        pixel = {5'h1F, 5'h00, rx_q[4:0]};
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_chan(input logic [4:0] c, input logic odd);
        logic [4:0] v;
        v = c;
`ifdef SCANLINES_EN
        if (odd) v = c >> 1;
`endif
        return v[4:1];
    endfunction

    task automatic check_rgb(input string tag, input logic [4:0] er, input logic [4:0] eg,
                             input logic [4:0] eb, input logic odd);
        check(tag, int'({vr, vg, vb}),
              int'({exp_chan(er, odd), exp_chan(eg, odd), exp_chan(eb, odd)}));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic int pos_h();
        return cyc % HT;
    endfunction

    function automatic int pos_v();
        return (cyc / HT) % VT;
    endfunction

    task automatic goto(input int v, input int h);
        int lim;
        lim = HT * VT + 1;
        while (!(pos_v() == v && pos_h() == h) && lim > 0) begin
            tick();
            lim--;
        end
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int rises, width, wmin, wmax, first_v, first_h, vs_low, rf_high;
        logic prev;
        logic [11:0] rgb_or;

        reset_n = 1'b0;
        frame_available = 1'b0;
        f_fa = 1'b0;
        f_pixel = 15'h0000;
        pixel = 15'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_hsync", hs, 1);
        check("rst_vsync", vs, 1);
        check("rst_blank", bl, 1);
        check("rst_rgb", {vr, vg, vb}, 0);
        check("rst_read_x", rx, 0);
        check("rst_reset_line", rl, 0);
        check("rst_reset_frame", rf, 1);
        check("rst_state", st, 0);
        check("rst_full_hsync", f_hs, 1);

        reset_n = 1'b1;
        cyc = 0;

        // Full-size line timing.
        goto_cyc(1);
        check("rf_drop", f_rf, 0);
        goto_cyc(2);
        check("blank_pipe_c2", f_bl, 1);
        goto_cyc(3);
        check("blank_hc0", f_bl, 0);
        goto_cyc(642);
        check("blank_hc639", f_bl, 0);
        goto_cyc(643);
        check("blank_hc640", f_bl, 1);
        goto_cyc(658);
        check("hsync_before", f_hs, 1);
        goto_cyc(659);
        check("hsync_fall", f_hs, 0);
        goto_cyc(754);
        check("hsync_last_low", f_hs, 0);
        goto_cyc(755);
        check("hsync_rise", f_hs, 1);
        goto_cyc(1458);
        check("hsync_p_before", f_hs, 1);
        goto_cyc(1459);
        check("hsync_period", f_hs, 0);

        // One whole small frame with frame_available still low.
        goto(0, 0);
        rises = 0; width = 0; wmin = 999; wmax = 0;
        first_v = -1; first_h = -1; vs_low = 0; rf_high = 0; rgb_or = '0;
        prev = rl;
        for (int i = 0; i < HT * VT; i++) begin
            if (rl && !prev) begin
                rises++;
                width = 0;
                if (first_v < 0) begin
                    first_v = pos_v();
                    first_h = pos_h();
                end
            end
            if (rl) width++;
            if (!rl && prev) begin
                if (width < wmin) wmin = width;
                if (width > wmax) wmax = width;
            end
            prev = rl;
            if (!vs) vs_low++;
            if (rf) rf_high++;
            rgb_or = rgb_or | {vr, vg, vb};
            if (pos_v() == 15 && pos_h() == 2) check("vsync_pre", vs, 1);
            if (pos_v() == 15 && pos_h() == 3) check("vsync_fall", vs, 0);
            if (pos_v() == 17 && pos_h() == 3) check("vsync_rise", vs, 1);
            tick();
        end
        check("rl_pulses", rises, 8);
        check("rl_wmin", wmin, 4);
        check("rl_wmax", wmax, 4);
        check("rl_first_v", first_v, 1);
        check("rl_first_h", first_h, 48);
        check("vsync_low_cnt", vs_low, 2 * HT);
        check("rf_high_cnt", rf_high, HT);
        check("idle_rgb", rgb_or, 0);
        check("idle_state", st, 0);

        // Arm mid-frame; display must wait for the next frame start.
        goto(5, 20);
        frame_available = 1'b1;
        tick();
        frame_available = 1'b0;
        check("armed_state", st, 1);
        rgb_or = '0;
        while (!(pos_v() == 0 && pos_h() == 0)) begin
            rgb_or = rgb_or | {vr, vg, vb};
            tick();
        end
        check("armed_rgb", rgb_or, 0);
        check("show_state", st, 2);
        goto(0, 2);
        check("show_pipe_rgb", {vr, vg, vb}, 0);
        goto(0, 3);
        check_rgb("border_l0", 5'h16, 5'h15, 5'h16, 1'b0);
        goto(2, 11);
        check_rgb("pic_x0", 5'h00, 5'h00, 5'h1F, 1'b0);
        goto(2, 16);
        check_rgb("pic_x5", 5'h05, 5'h00, 5'h1F, 1'b0);
        goto(2, 40);
        check("read_x_x31", rx, 10'h01F);
        goto(2, 42);
        check_rgb("pic_x31", 5'h1F, 5'h00, 5'h1F, 1'b0);
        goto(2, 50);
        check("blank_in", bl, 0);
        check_rgb("pic_x39", 5'h07, 5'h00, 5'h1F, 1'b0);
        goto(2, 51);
        check("blank_out", bl, 1);
        check("blank_rgb", {vr, vg, vb}, 0);
        goto(3, 3);
        check_rgb("border_l3", 5'h16, 5'h15, 5'h16, 1'b1);
        goto(3, 9);
        check("read_x_row", rx, 10'h200);
        goto(3, 11);
        check_rgb("pic_l3_x0", 5'h00, 5'h00, 5'h1F, 1'b1);

        // Reset during a reset_line pulse.
        goto(5, 49);
        check("rl_inflight", rl, 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_rl", rl, 0);
        check("mid_rst_hsync", hs, 1);
        check("mid_rst_rf", rf, 1);
        check("mid_rst_rgb", {vr, vg, vb}, 0);
        check("mid_rst_blank", bl, 1);
        check("mid_rst_read_x", rx, 0);
        check("mid_rst_state", st, 0);
        reset_n = 1'b1;
        cyc = 0;
        goto_cyc(1);
        check("rerun_rf", rf, 0);
        goto_cyc(3);
        check("rerun_blank", bl, 0);
        goto_cyc(20);
        check("rerun_rgb", {vr, vg, vb}, 0);
        check("rerun_state", st, 0);
        goto_cyc(54);
        check("rerun_hs_before", hs, 1);
        goto_cyc(55);
        check("rerun_hs_fall", hs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
